// File: rtl/postadder_nthread.sv
// Post-adder for the thread-interleaved Fp/Fp2 datapath: recombines multiplier products
// into (Z0, Z1) per thread. Optional macro POSTADDER_NONNEG_EN folds negative results by +MOD_OFS.
module postadder_nthread #(
  parameter int N_THREADS = 4,
  parameter int DW        = 16,
  parameter int OW        = DW + 2,
  parameter int MOD_OFS   = 2 ** (DW + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  input  logic [1:0]                   mode,
  input  logic [DW-1:0]                P,
  output logic                         out_valid,
  output logic [$clog2(N_THREADS)-1:0] out_tid,
  output logic [OW-1:0]                Z0,
  output logic [OW-1:0]                Z1,
  output logic                         busy
);

  localparam int TW = $clog2(N_THREADS);
  localparam logic [TW-1:0] TID_MAX = TW'(N_THREADS - 1);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_FP2  = 2'b01;
  localparam logic [1:0] MODE_SD   = 2'b10;

`ifdef POSTADDER_NONNEG_EN
  localparam bit NONNEG = 1'b1;
`else
  localparam bit NONNEG = 1'b0;
`endif
  localparam logic signed [OW-1:0] OFS = OW'(MOD_OFS);

  logic [TW-1:0] tid;
  logic [1:0]    beat;
  logic [1:0]    act_mode;
  logic [DW-1:0] v0 [N_THREADS];
  logic [DW-1:0] v1 [N_THREADS];

  logic                 group_start;
  logic [1:0]           mode_in;
  logic [1:0]           eff_mode;
  logic [1:0]           last_beat;
  logic                 final_beat;
  logic [DW-1:0]        head0;
  logic [DW-1:0]        head1;
  logic signed [OW-1:0] a0, a1, ap;
  logic signed [OW-1:0] z0_raw, z1_raw, z0_n, z1_n;

  assign group_start = (tid == '0) && (beat == 2'd0);
  assign mode_in     = (mode == 2'b11) ? MODE_PASS : mode;
  // The group's mode is live on its first beat, before it has been latched.
  assign eff_mode    = group_start ? mode_in : act_mode;
  assign final_beat  = (beat == last_beat);
  assign head0       = v0[N_THREADS-1];
  assign head1       = v1[N_THREADS-1];
  assign a0          = {{(OW-DW){1'b0}}, head0};
  assign a1          = {{(OW-DW){1'b0}}, head1};
  assign ap          = {{(OW-DW){1'b0}}, P};
  assign busy        = (tid != '0) || (beat != 2'd0);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    last_beat = 2'd0;
    z0_raw    = ap;
    z1_raw    = '0;
    case (eff_mode)
      MODE_SD: begin
        last_beat = 2'd1;
        z0_raw    = a0 + ap;
        z1_raw    = a0 - ap;
      end
      MODE_FP2: begin
        last_beat = 2'd2;
        z0_raw    = a0 - a1;
        z1_raw    = ap - a0 - a1;
      end
      default: ;
    endcase
    z0_n = z0_raw;
    z1_n = z1_raw;
    if (NONNEG && z0_raw < 0) z0_n = z0_raw + OFS;
    if (NONNEG && z1_raw < 0) z1_n = z1_raw + OFS;
  end

  // NOTE: the buffers sit in the async reset so a discarded group leaves no stale data;
  // all state uses non-blocking assignments so the shift chain moves one slot per edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tid       <= '0;
      beat      <= 2'd0;
      act_mode  <= MODE_PASS;
      out_valid <= 1'b0;
      out_tid   <= '0;
      Z0        <= '0;
      Z1        <= '0;
      for (int i = 0; i < N_THREADS; i++) begin
        v0[i] <= '0;
        v1[i] <= '0;
      end
    end else begin
      out_valid <= in_valid && final_beat;
      if (in_valid) begin
        if (group_start) act_mode <= mode_in;
        if (tid == TID_MAX) begin
          tid  <= '0;
          beat <= final_beat ? 2'd0 : beat + 2'd1;
        end else begin
          tid <= tid + TW'(1);
        end
        // Buffers not being loaded recirculate their head so each head tracks tid.
        v0[0] <= (beat == 2'd0) ? P : head0;
        v1[0] <= (beat == 2'd1) ? P : head1;
        for (int i = 1; i < N_THREADS; i++) begin
          v0[i] <= v0[i-1];
          v1[i] <= v1[i-1];
        end
        if (final_beat) begin
          out_tid <= tid;
          Z0      <= z0_n;
          Z1      <= z1_n;
        end
      end
    end
  end

endmodule
